// File: rtl/matrix_vec_mult_core.sv
// Serial-MAC 2D homogeneous transform core: returns x' then y' of T*[x y 1]^T.
// Optional build macro MVC_SATURATE_EN clamps results instead of wrapping.
module matrix_vec_mult_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic signed [DATA_WIDTH-1:0]   x_in,
  input  logic signed [DATA_WIDTH-1:0]   y_in,
  input  logic [1:0]                     transform_type,
  input  logic signed [DATA_WIDTH-1:0]   param1,
  input  logic signed [DATA_WIDTH-1:0]   param2,
  input  logic                           cfg_we,
  input  logic [3:0]                     cfg_addr,
  input  logic signed [DATA_WIDTH-1:0]   cfg_data,
  output logic                           busy,
  output logic signed [2*DATA_WIDTH-1:0] matrix_result,
  output logic                           matrix_valid,
  output logic                           done
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int AW = PW + 2;
  localparam logic signed [DW-1:0] ZERO_C    = {DW{1'b0}};
  localparam logic signed [DW-1:0] ONE_C     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic signed [DW-1:0] NEG_ONE_C = {DW{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, EMIT = 2'd2} state_t;

  state_t               state_r, state_s;
  logic signed [DW-1:0] cfg_r [0:5];
  logic signed [DW-1:0] m_r   [0:5];
  logic signed [DW-1:0] mat_s [0:5];
  logic signed [DW-1:0] x_r, y_r, m_sel_s, v_sel_s;
  logic                 row_r;
  logic [1:0]           col_r;
  logic signed [AW-1:0] acc_r;
  logic signed [PW-1:0] prod_s, red_s, result_r;
  logic                 busy_r, valid_r, done_r;

  assign busy          = busy_r;
  assign matrix_result = result_r;
  assign matrix_valid  = valid_r;
  assign done          = done_r;

  // Build rows 0..1 of the transform matrix from the request inputs
  always_comb begin
    for (int i = 0; i < 6; i++) mat_s[i] = ZERO_C;
    case (transform_type)
      2'b00: begin
        case (param1[1:0])
          2'd0: begin mat_s[0] = ONE_C;     mat_s[4] = ONE_C;     end
          2'd1: begin mat_s[1] = NEG_ONE_C; mat_s[3] = ONE_C;     end
          2'd2: begin mat_s[0] = NEG_ONE_C; mat_s[4] = NEG_ONE_C; end
          default: begin mat_s[1] = ONE_C;  mat_s[3] = NEG_ONE_C; end
        endcase
      end
      2'b01: begin mat_s[0] = param1; mat_s[4] = param2; end
      2'b10: begin
        mat_s[0] = ONE_C; mat_s[2] = param1;
        mat_s[4] = ONE_C; mat_s[5] = param2;
      end
      2'b11:   for (int i = 0; i < 6; i++) mat_s[i] = cfg_r[i];
      default: for (int i = 0; i < 6; i++) mat_s[i] = ZERO_C;
    endcase
  end

  // Select the matrix element and vector component for the current MAC step
  always_comb begin
    case (col_r)
      2'd0:    begin m_sel_s = row_r ? m_r[3] : m_r[0]; v_sel_s = x_r;   end
      2'd1:    begin m_sel_s = row_r ? m_r[4] : m_r[1]; v_sel_s = y_r;   end
      default: begin m_sel_s = row_r ? m_r[5] : m_r[2]; v_sel_s = ONE_C; end
    endcase
  end

  assign prod_s = PW'(m_sel_s) * PW'(v_sel_s);

  // Reduce the wide accumulator to the output width
`ifdef MVC_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX_C = {3'b000, {(PW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN_C = {3'b111, {(PW-1){1'b0}}};
  always_comb begin
    if (acc_r > SAT_MAX_C) begin
      red_s = {1'b0, {(PW-1){1'b1}}};
    end else if (acc_r < SAT_MIN_C) begin
      red_s = {1'b1, {(PW-1){1'b0}}};
    end else begin
      red_s = acc_r[PW-1:0];
    end
  end
`else
  always_comb begin
    red_s = acc_r[PW-1:0];
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = MAC;  else state_s = IDLE;
      MAC:     if (col_r == 2'd2) state_s = EMIT; else state_s = MAC;
      EMIT:    if (row_r) state_s = IDLE; else state_s = MAC;
      default: state_s = IDLE;
    endcase
  end

  // Custom matrix registers; only writable while idle, rows 0..1 are ever read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) cfg_r[i] <= (i == 0 || i == 4) ? ONE_C : ZERO_C;
    end else if (state_r == IDLE && cfg_we && cfg_addr < 4'd6) begin
      cfg_r[cfg_addr[2:0]] <= cfg_data;
    end
  end

  // Datapath: operand latch, serial MAC and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_r[i] <= ZERO_C;
      x_r <= ZERO_C; y_r <= ZERO_C;
      row_r <= 1'b0; col_r <= 2'd0; acc_r <= '0;
      result_r <= '0; valid_r <= 1'b0; done_r <= 1'b0; busy_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 6; i++) m_r[i] <= mat_s[i];
            x_r <= x_in; y_r <= y_in;
            row_r <= 1'b0; col_r <= 2'd0; acc_r <= '0;
            busy_r <= 1'b1;
          end
        end
        MAC: begin
          acc_r <= acc_r + AW'(prod_s);
          col_r <= col_r + 2'd1;
        end
        EMIT: begin
          result_r <= red_s;
          valid_r  <= 1'b1;
          acc_r    <= '0;
          col_r    <= 2'd0;
          row_r    <= 1'b1;
          if (row_r) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            row_r  <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
